// File: rtl/cov_counter_reader.sv
// Coverage-counter readout: freezes the per-point toggle counters, streams
// (index, count, hit) in index order and accumulates hit / condition-hit totals.
module cov_counter_reader #(
    parameter int NUM_POINTS = 14,
    parameter int NUM_BIN    = 5,
    parameter int CNT_W      = 32,
    parameter int IDX_W      = (NUM_POINTS > 1) ? $clog2(NUM_POINTS) : 1,
    localparam int HIT_W     = $clog2(NUM_POINTS + 1),
    localparam int COND_W    = (NUM_BIN > 0) ? $clog2(NUM_BIN + 1) : 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_POINTS*CNT_W-1:0] cnt_flat,
    input  logic                        en_req,
    output logic                        cov_en,
    output logic                        cov_clear,
    input  logic                        start,
    input  logic                        clear_on_done,
    input  logic                        clear_req,
    output logic                        busy,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [IDX_W-1:0]            out_idx,
    output logic [CNT_W-1:0]            out_count,
    output logic                        out_hit,
    output logic                        done,
    output logic [HIT_W-1:0]            hit_total,
    output logic [COND_W-1:0]           cond_total,
    output logic [1:0]                  state_dbg
);

    localparam int LAST_IDX = NUM_POINTS - 1;
    localparam int BIN_BASE = NUM_POINTS - NUM_BIN;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    out_idx_q, out_idx_d;
    logic [CNT_W-1:0]    out_count_q, out_count_d;
    logic [HIT_W-1:0]    hit_total_q, hit_total_d;
    logic [COND_W-1:0]   cond_total_q, cond_total_d;
    logic                clear_latch_q, clear_latch_d;
    logic                cov_clear_q, cov_clear_d;

    logic                is_last;
    logic                is_bin;
    logic [IDX_W-1:0]    next_idx;
    logic [IDX_W-1:0]    sel_idx;
    logic [CNT_W-1:0]    next_count;

    // Output stream: an element transfers on a clock edge where out_valid and
    // out_ready are both high; until then out_idx/out_count/out_hit hold
    // stable and out_valid never drops. out_ready may change freely.
    assign out_valid  = (state_q == ST_SCAN);
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign cov_en     = en_req & ~busy;
    assign cov_clear  = cov_clear_q;
    assign out_idx    = out_idx_q;
    assign out_count  = out_count_q;
    assign out_hit    = |out_count_q;
    assign hit_total  = hit_total_q;
    assign cond_total = cond_total_q;
    assign state_dbg  = state_q;

    assign is_last  = (int'(out_idx_q) == LAST_IDX);
    assign is_bin   = (int'(out_idx_q) >= BIN_BASE);
    assign next_idx = out_idx_q + IDX_W'(1);
    // Clamp so the part-select never reaches past the last counter.
    assign sel_idx    = is_last ? out_idx_q : next_idx;
    assign next_count = cnt_flat[int'(sel_idx)*CNT_W +: CNT_W];

    always_comb begin
        state_d        = state_q;
        out_idx_d      = out_idx_q;
        out_count_d    = out_count_q;
        hit_total_d    = hit_total_q;
        cond_total_d   = cond_total_q;
        clear_latch_d  = clear_latch_q;
        cov_clear_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d       = ST_SCAN;
                    out_idx_d     = '0;
                    out_count_d   = cnt_flat[CNT_W-1:0];
                    hit_total_d   = '0;
                    cond_total_d  = '0;
                    // A clear requested together with start waits for scan end.
                    clear_latch_d = clear_on_done | clear_req;
                end else if (clear_req) begin
                    cov_clear_d = 1'b1;
                end
            end
            ST_SCAN: begin
                if (out_ready) begin
                    hit_total_d = hit_total_q + HIT_W'(out_hit);
                    if (is_bin) begin
                        cond_total_d = cond_total_q + COND_W'(out_hit);
                    end
                    if (is_last) begin
                        state_d     = ST_DONE;
                        cov_clear_d = clear_latch_q;
                    end else begin
                        out_idx_d   = next_idx;
                        out_count_d = next_count;
                    end
                end
            end
            ST_DONE: begin
                state_d       = ST_IDLE;
                clear_latch_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            out_idx_q     <= '0;
            out_count_q   <= '0;
            hit_total_q   <= '0;
            cond_total_q  <= '0;
            clear_latch_q <= 1'b0;
            cov_clear_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            out_idx_q     <= out_idx_d;
            out_count_q   <= out_count_d;
            hit_total_q   <= hit_total_d;
            cond_total_q  <= cond_total_d;
            clear_latch_q <= clear_latch_d;
            cov_clear_q   <= cov_clear_d;
        end
    end

endmodule
